// File: rtl/fetch_prefetch.sv
// Instruction-fetch stage: issues sequential word reads to a synchronous RAM,
// buffers returned words in a small FIFO, and hands them to the decoder.
module fetch_prefetch #(
  parameter int                  LGMEMSZ  = 14,
  parameter int                  LGFIFO   = 2,
  parameter logic [LGMEMSZ-1:0]  RESET_PC = '0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  output logic               o_mem_read,
  output logic [LGMEMSZ-1:0] o_mem_address,
  input  logic [31:0]        i_mem_data,
  input  logic               i_redirect,
  input  logic [LGMEMSZ-1:0] i_redirect_pc,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [31:0]        o_instr,
  output logic [LGMEMSZ-1:0] o_pc
);

  localparam int              DEPTH     = 1 << LGFIFO;
  localparam logic [LGFIFO:0] DEPTH_CNT = (LGFIFO+1)'(DEPTH);

  logic [LGMEMSZ-1:0] fetch_pc_q, fetch_pc_d;
  logic               inflight_q, inflight_d;
  logic [LGMEMSZ-1:0] inflight_pc_q, inflight_pc_d;
  logic [LGFIFO-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LGFIFO-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LGFIFO:0]    count_q, count_d;
  logic [31:0]        instr_q [DEPTH];
  logic [LGMEMSZ-1:0] pc_q    [DEPTH];

  logic            issue, push, pop;
  logic [LGFIFO:0] credit_used;

  always_comb begin
    // A read in flight already owns a FIFO slot, so it counts against the depth.
    credit_used = count_q + {{LGFIFO{1'b0}}, inflight_q};
    issue       = !i_reset && !i_redirect && (credit_used < DEPTH_CNT);
    push        = inflight_q && !i_redirect;
    pop         = (count_q != '0) && i_ready && !i_redirect;

    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    if (i_redirect) begin
      fetch_pc_d = i_redirect_pc;
      inflight_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + 1'b1;
        inflight_pc_d = fetch_pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{LGFIFO{1'b0}}, push} - {{LGFIFO{1'b0}}, pop};
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Entries are cleared on reset so the head reads as zero before any fill.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (push) begin
      instr_q[wr_ptr_q] <= i_mem_data;
      pc_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  assign o_mem_read    = issue;
  assign o_mem_address = fetch_pc_q;
  assign o_valid       = (count_q != '0);
  assign o_instr       = instr_q[rd_ptr_q];
  assign o_pc          = pc_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_prefetch.sv
// Randomized bench for fetch_prefetch: queue-based reference model plus
// hand-computed pins for fill latency, backpressure, redirect and PC wrap.
module tb_fetch_prefetch;

  logic        clk = 1'b0;
  logic        i_reset, i_redirect, i_ready;
  logic [13:0] i_redirect_pc;
  logic        o_mem_read, o_valid;
  logic [13:0] o_mem_address, o_pc;
  logic [31:0] o_instr, mem_rdata;

  logic        w_mem_read, w_valid;
  logic [13:0] w_mem_address, w_pc;
  logic [31:0] w_instr, w_rdata;

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [13:0] a);
    return 32'h0000_00A0 + {18'h0, a};
  endfunction

  always @(posedge clk) if (o_mem_read) mem_rdata <= ram_word(o_mem_address);
  always @(posedge clk) if (w_mem_read) w_rdata   <= ram_word(w_mem_address);

  fetch_prefetch u_dut (
    .i_clk(clk), .i_reset(i_reset),
    .o_mem_read(o_mem_read), .o_mem_address(o_mem_address), .i_mem_data(mem_rdata),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr), .o_pc(o_pc)
  );

  fetch_prefetch #(.RESET_PC(14'd16382)) u_wrap (
    .i_clk(clk), .i_reset(i_reset),
    .o_mem_read(w_mem_read), .o_mem_address(w_mem_address), .i_mem_data(w_rdata),
    .i_redirect(1'b0), .i_redirect_pc(14'h0),
    .o_valid(w_valid), .i_ready(i_ready), .o_instr(w_instr), .o_pc(w_pc)
  );

  // Reference model: words buffered, the single outstanding read, next fetch PC.
  logic [13:0] m_q[$];
  logic        m_pend_v;
  logic [13:0] m_pend_pc;
  logic [13:0] m_pc;

  int n_vec = 0;
  int n_err = 0;

  logic        obs_valid, obs_read, w_obs_valid;
  logic [13:0] obs_addr, obs_pc, w_obs_pc, w_obs_addr;
  logic [31:0] obs_instr, w_obs_instr;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_pend_v = 1'b0;
    m_pc     = 14'h0;
  endtask

  function automatic logic m_issue();
    return !i_reset && !i_redirect && ((m_q.size() + int'(m_pend_v)) < 4);
  endfunction

  task automatic check();
    logic ev;
    ev = (m_q.size() != 0);
    obs_valid = o_valid; obs_read = o_mem_read; obs_addr = o_mem_address;
    obs_pc = o_pc; obs_instr = o_instr;
    w_obs_valid = w_valid; w_obs_pc = w_pc; w_obs_addr = w_mem_address; w_obs_instr = w_instr;
    cmp("o_valid", {31'h0, o_valid}, {31'h0, ev});
    cmp("o_mem_read", {31'h0, o_mem_read}, {31'h0, m_issue()});
    cmp("o_mem_address", {18'h0, o_mem_address}, {18'h0, m_pc});
    if (ev) begin
      cmp("o_pc", {18'h0, o_pc}, {18'h0, m_q[0]});
      cmp("o_instr", o_instr, ram_word(m_q[0]));
    end
  endtask

  task automatic m_clock();
    logic iss, popped;
    if (i_reset) begin
      m_reset();
    end else if (i_redirect) begin
      m_q.delete();
      m_pend_v = 1'b0;
      m_pc     = i_redirect_pc;
    end else begin
      iss    = m_issue();
      popped = i_ready && (m_q.size() != 0);
      if (popped) void'(m_q.pop_front());
      if (m_pend_v) m_q.push_back(m_pend_pc);
      m_pend_v = iss;
      if (iss) begin
        m_pend_pc = m_pc;
        m_pc      = m_pc + 14'd1;
      end
    end
  endtask

  task automatic step(input logic rst, input logic redir, input logic [13:0] rpc, input logic rdy);
    @(negedge clk);
    i_reset = rst; i_redirect = redir; i_redirect_pc = rpc; i_ready = rdy;
    if (rst) m_reset();
    #1 check();
    @(posedge clk);
    m_clock();
  endtask

  initial begin
    int reads;
    i_reset = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0; i_ready = 1'b0;
    m_reset();

    // Reset state, then fill with i_ready high.
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    cmp("rst_valid", {31'h0, obs_valid}, 32'd0);
    cmp("rst_read", {31'h0, obs_read}, 32'd0);
    cmp("rst_pc", {18'h0, obs_pc}, 32'd0);
    cmp("rst_instr", obs_instr, 32'd0);
    step(0, 0, 0, 1);
    cmp("fill_read0", {31'h0, obs_read}, 32'd1);
    cmp("fill_addr0", {18'h0, obs_addr}, 32'd0);
    cmp("wrap_addr0", {18'h0, w_obs_addr}, 32'd16382);
    step(0, 0, 0, 1);
    cmp("fill_valid1", {31'h0, obs_valid}, 32'd0);
    cmp("wrap_addr1", {18'h0, w_obs_addr}, 32'd16383);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 1);
      cmp("stream_valid", {31'h0, obs_valid}, 32'd1);
      cmp("stream_pc", {18'h0, obs_pc}, k);
      cmp("stream_instr", obs_instr, 32'hA0 + k);
      cmp("wrap_valid", {31'h0, w_obs_valid}, 32'd1);
      cmp("wrap_pc", {18'h0, w_obs_pc}, (16382 + k) % 16384);
      cmp("wrap_instr", w_obs_instr, ram_word(14'((16382 + k) % 16384)));
    end

    // Backpressure from reset: exactly four reads, then one pop frees one slot.
    step(1, 0, 0, 0);
    reads = 0;
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 0, 0);
      if (obs_read) reads++;
    end
    cmp("bp_reads", reads, 32'd4);
    cmp("bp_valid", {31'h0, obs_valid}, 32'd1);
    step(0, 0, 0, 1);
    cmp("bp_pop_instr", obs_instr, 32'hA0);
    cmp("bp_pop_read", {31'h0, obs_read}, 32'd0);
    step(0, 0, 0, 0);
    cmp("bp_refill_read", {31'h0, obs_read}, 32'd1);
    cmp("bp_refill_addr", {18'h0, obs_addr}, 32'd4);

    // Redirect with 3 buffered + 1 inflight, coinciding with a pop and an arrival.
    step(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0);
    step(0, 1, 14'h0100, 1);
    cmp("redir_read", {31'h0, obs_read}, 32'd0);
    step(0, 0, 0, 1);
    cmp("redir_r1_valid", {31'h0, obs_valid}, 32'd0);
    cmp("redir_r1_addr", {18'h0, obs_addr}, 32'h100);
    step(0, 0, 0, 1);
    cmp("redir_r2_valid", {31'h0, obs_valid}, 32'd0);
    step(0, 0, 0, 1);
    cmp("redir_r3_valid", {31'h0, obs_valid}, 32'd1);
    cmp("redir_r3_pc", {18'h0, obs_pc}, 32'h100);
    cmp("redir_r3_instr", obs_instr, 32'h1A0);

    // Reset while full: outputs drop without waiting for a clock edge.
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    cmp("async_valid", {31'h0, obs_valid}, 32'd0);
    cmp("async_read", {31'h0, obs_read}, 32'd0);
    step(0, 0, 0, 1);
    cmp("restart_addr", {18'h0, obs_addr}, 32'd0);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      logic        rst, redir, rdy;
      logic [13:0] rpc;
      rst   = ($urandom_range(0, 199) == 0);
      redir = ($urandom_range(0, 19) == 0);
      rdy   = ($urandom_range(0, 3) != 0);
      rpc   = ($urandom_range(0, 1) == 0) ? 14'(16380 + $urandom_range(0, 3)) : 14'($urandom);
      step(rst, redir, rpc, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
